max_pool_seq: RTL and testbench

//  Sequenced max-pooling / argmax engine for sign-magnitude fixed-point samples.
//  - Accepts a window of cfg_len samples over a valid/ready stream.
//  - Returns the largest sample value and its index within the window.
//  - Sits between the PPG feature stream and the pooling/decision stage.
//  - Holds one running-max register and reuses a single sign-magnitude

---
 rtl/max_pool_seq.sv | 131 +++++++++++++
 tb/tb_max_pool_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_seq.sv
// rtl/max_pool_seq.sv - sequenced sign-magnitude max-pool / argmax over a streamed window
module max_pool_seq #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_max,
    output logic [LEN_W-1:0] out_idx
);

    // Q only documents the sample format; the ordering never depends on it.
    if (Q >= N) begin : g_bad_q
        $error("max_pool_seq: Q must be smaller than N");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [N-1:0]     acc_max_q;
    logic [LEN_W-1:0] acc_idx_q;
    logic [N-1:0]     out_max_q;
    logic [LEN_W-1:0] out_idx_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [N-1:0]     max_d;
    logic [LEN_W-1:0] idx_d;
    logic             hs;
    logic             last;

    // Strict sign-magnitude "a > b"; +0 and -0 are equal, so ties never replace.
    function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] ma;
        logic [N-2:0] mb;
        ma = a[N-2:0];
        mb = b[N-2:0];
        if (ma == '0 && mb == '0)
            return 1'b0;
        if (a[N-1] != b[N-1])
            return b[N-1];
        if (!a[N-1])
            return ma > mb;
        return ma < mb;
    endfunction

    always_comb begin
        hs    = in_valid & in_ready_q;
        last  = (cnt_q == len_q - LEN_W'(1));
        max_d = acc_max_q;
        idx_d = acc_idx_q;
        if (cnt_q == '0 || sm_gt(in_data, acc_max_q)) begin
            max_d = in_data;
            idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_max_q   <= '0;
            acc_idx_q   <= '0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && cfg_len != '0) begin
                        state_q    <= S_ACC;
                        len_q      <= cfg_len;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (hs) begin
                        acc_max_q <= max_d;
                        acc_idx_q <= idx_d;
                        cnt_q     <= cnt_q + LEN_W'(1);
                        if (last) begin
                            // Result registers only move on a completed window.
                            out_max_q   <= max_d;
                            out_idx_q   <= idx_d;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_max_pool_seq.sv
// tb/tb_max_pool_seq.sv - directed self-checking bench for max_pool_seq
module tb_max_pool_seq;

    localparam int N     = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_max;
    logic [LEN_W-1:0] out_idx;

    int n_vec = 0;
    int n_err = 0;

    max_pool_seq #(.Q(15), .N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
        cfg_len = '0;
    endtask

    task automatic send(input logic [N-1:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready)
            check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [N-1:0] emax, input logic [LEN_W-1:0] eidx);
        int k;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_max"}, {32'd0, out_max}, {32'd0, emax});
        check({tag, "_idx"}, {56'd0, out_idx}, {56'd0, eidx});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_max", {32'd0, out_max}, 64'd0);
        check("rst_out_idx", {56'd0, out_idx}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Mixed signs: +1.0, -3.0, +2.5, +0.5
        do_start(8'd4);
        check("t2_busy", {63'd0, busy}, 64'd1);
        check("t2_in_ready", {63'd0, in_ready}, 64'd1);
        send(32'h0000_8000);
        send(32'h8001_8000);
        send(32'h0001_4000);
        check("t2_no_early_valid", {63'd0, out_valid}, 64'd0);
        send(32'h0000_4000);
        check("t2_latency1", {63'd0, out_valid}, 64'd1);
        check("t2_in_ready_off", {63'd0, in_ready}, 64'd0);
        get("t2", 32'h0001_4000, 8'd2);

        // All negative with a tie: -2.0, -0.25, -0.25
        do_start(8'd3);
        send(32'h8001_0000);
        send(32'h8000_2000);
        send(32'h8000_2000);
        get("t3", 32'h8000_2000, 8'd1);

        // -0 then +0 compare equal, earlier kept
        do_start(8'd2);
        send(32'h8000_0000);
        send(32'h0000_0000);
        get("t4", 32'h8000_0000, 8'd0);

        // Input gaps, output backpressure, start ignored in OUT
        do_start(8'd3);
        send(32'h0000_0005);
        tick(); tick();
        send(32'h8000_0007);
        tick();
        send(32'h0000_0009);
        start   = 1'b1;
        cfg_len = 8'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t5_hold_max", {32'd0, out_max}, 64'h9);
            check("t5_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        check("t5_start_in_out_ignored", {63'd0, busy}, 64'd0);
        check("t5_in_ready_idle", {63'd0, in_ready}, 64'd0);
        tick();
        check("t5_still_idle", {63'd0, busy}, 64'd0);
        do_start(8'd0);
        check("t5_len0_busy", {63'd0, busy}, 64'd0);
        check("t5_len0_in_ready", {63'd0, in_ready}, 64'd0);
        check("t5_result_kept", {56'd0, out_idx}, 64'd2);

        // Abort after 2 of 5 with a handshake in the abort cycle
        do_start(8'd5);
        send(32'h0000_1111);
        send(32'h0000_2222);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h7FFF_FFFF;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t6_abort_busy", {63'd0, busy}, 64'd0);
        check("t6_abort_in_ready", {63'd0, in_ready}, 64'd0);
        check("t6_abort_no_valid", {63'd0, out_valid}, 64'd0);
        check("t6_abort_max_kept", {32'd0, out_max}, 64'h9);
        tick(); tick();
        check("t6_abort_no_valid_late", {63'd0, out_valid}, 64'd0);
        do_start(8'd1);
        send(32'h7FFF_FFFF);
        get("t6", 32'h7FFF_FFFF, 8'd0);

        // Longest window: ascending positives, peak at the last index
        do_start(8'd255);
        for (int i = 0; i < 255; i++) begin
            send(32'(i));
            if (i < 254)
                check("t7_no_early_valid", {63'd0, out_valid}, 64'd0);
        end
        get("t7", 32'd254, 8'd254);

        // Async reset mid-window with in_valid high
        do_start(8'd4);
        send(32'h0000_0100);
        in_valid = 1'b1;
        in_data  = 32'h7FFF_0000;
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_busy", {63'd0, busy}, 64'd0);
        check("t1_in_ready", {63'd0, in_ready}, 64'd0);
        check("t1_out_valid", {63'd0, out_valid}, 64'd0);
        check("t1_out_max", {32'd0, out_max}, 64'd0);
        check("t1_out_idx", {56'd0, out_idx}, 64'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("t1_after_reset_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
